// File: rtl/r_mem_reader_if.sv
// Output stream of the R/modulus ROM reader: one word per valid/ready handshake,
// with a last marker on the final word of a run.
interface r_mem_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/r_mem_reader.sv
// Sequencer around the constant ROM: issues a contiguous address run, realigns the
// ROM's fixed read latency with a tag pipe and streams words out through a credit-limited FIFO.
module r_mem_reader #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_q,
  r_mem_reader_if.master        out_if
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic                    done_q, done_d;
  logic                    last_accepted_q, last_accepted_d;

  logic [READ_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [READ_LATENCY-1:0] tag_last_q, tag_last_d;

  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;

  logic [CRD_W-1:0]        inflight;
  logic                    credit_ok;
  logic                    issue;
  logic                    issue_last;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;

  assign fifo_empty = (fifo_count_q == '0);
  assign push       = tag_valid_q[READ_LATENCY-1];
  assign pop        = out_if.out_valid && out_if.out_ready;

  // Every issued read owns a FIFO slot until it is popped, so issuing only while
  // (tags in flight + stored words) < depth makes overflow impossible.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CRD_W'(tag_valid_q[i]);
    end
    credit_ok = ((CRD_W'(fifo_count_q) + inflight) < CRD_W'(FIFO_DEPTH));
  end

  // NOTE: every variable written in a combinational block gets a default first;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    next_addr_d     = next_addr_q;
    remaining_d     = remaining_q;
    mem_address_d   = mem_address_q;
    done_d          = 1'b0;
    last_accepted_d = last_accepted_q;
    issue           = 1'b0;
    issue_last      = 1'b0;

    if (pop && out_if.out_last) begin
      last_accepted_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            next_addr_d     = base_addr;
            remaining_d     = word_count;
            last_accepted_d = 1'b0;
            state_d         = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (credit_ok) begin
          issue         = 1'b1;
          issue_last    = (remaining_q == (ADDR_WIDTH + 1)'(1));
          mem_address_d = next_addr_q;
          next_addr_d   = next_addr_q + ADDR_WIDTH'(1);
          remaining_d   = remaining_q - (ADDR_WIDTH + 1)'(1);
          if (issue_last) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (fifo_empty && (inflight == '0) && last_accepted_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Tag pipe mirrors the ROM latency: a tag exits exactly when its word is on mem_q.
  always_comb begin
    tag_valid_d    = '0;
    tag_last_d     = '0;
    tag_valid_d[0] = issue;
    tag_last_d[0]  = issue_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_last_d[i]  = tag_last_q[i-1];
    end
  end

  always_comb begin
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_count_d = fifo_count_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // On a full FIFO the write lands in the slot being popped this same edge.
    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_q;
      fifo_last_d[wr_ptr_q] = tag_last_q[READ_LATENCY-1];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      next_addr_q     <= '0;
      remaining_q     <= '0;
      mem_address_q   <= '0;
      done_q          <= 1'b0;
      last_accepted_q <= 1'b0;
      tag_valid_q     <= '0;
      tag_last_q      <= '0;
      fifo_last_q     <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      fifo_count_q    <= '0;
      // NOTE: the FIFO storage is reset (not just its pointers) because its head
      // drives out_data, which must read 0 out of reset; only a few entries exist.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      next_addr_q     <= next_addr_d;
      remaining_q     <= remaining_d;
      mem_address_q   <= mem_address_d;
      done_q          <= done_d;
      last_accepted_q <= last_accepted_d;
      tag_valid_q     <= tag_valid_d;
      tag_last_q      <= tag_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      fifo_count_q    <= fifo_count_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign mem_address      = mem_address_q;
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_data_q[rd_ptr_q];
  assign out_if.out_last  = fifo_last_q[rd_ptr_q];

  a_fifo_no_overflow : assert property (
    @(posedge clock) disable iff (!reset_n)
    !(push && !pop && (fifo_count_q == CNT_W'(FIFO_DEPTH)))
  );

endmodule

// File: tb/tb_r_mem_reader.sv
// Randomized self-checking bench for r_mem_reader: a registered ROM model feeds the
// DUT and each run's expected word stream is computed from base/count address arithmetic.
module tb_r_mem_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic        busy;
  logic        done;
  logic [7:0]  mem_address;
  logic [31:0] mem_q = 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  r_mem_reader_if #(.DATA_WIDTH(32)) out_if ();

  r_mem_reader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_q       (mem_q),
    .out_if      (out_if)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return 32'h100 + 32'(a);
  endfunction

  // mem_address is the ROM's address register; the ROM contributes the output register.
  always @(posedge clock) mem_q <= rom_word(mem_address);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One run: mode selects the out_ready pattern; inject_cyc >= 0 fires a start
  // with base 0x80 mid-run, which must be ignored.
  task automatic run(input logic [7:0] base, input logic [8:0] count, input int mode,
                     input int inject_cyc);
    logic [31:0] exp_q[$];
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    logic        seen;
    int          cyc;
    int          first_valid;
    int          first_hs;
    int          last_hs;
    int          budget;

    for (int i = 0; i < int'(count); i++) exp_q.push_back(rom_word(8'(32'(base) + i)));
    budget      = int'(count) * 8 + 40;
    first_valid = -1;
    first_hs    = -1;
    last_hs     = -1;
    prev_stall  = 1'b0;
    prev_data   = '0;
    prev_last   = 1'b0;

    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    step();
    base_addr  = 8'h80;
    word_count = 9'd5;
    cyc        = 0;
    check("busy_after_start", busy, 1);

    while (1) begin
      start            = (cyc == inject_cyc);
      out_if.out_ready = ready_for(mode, cyc);

      if (prev_stall) begin
        check("stall_valid", out_if.out_valid, 1);
        check("stall_data", out_if.out_data, prev_data);
        check("stall_last", out_if.out_last, prev_last);
      end

      if (done) begin
        check("words_left", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        check("done_lat", cyc - last_hs, 2);
        if (mode == 0) check("no_bubbles", last_hs - first_hs, int'(count) - 1);
        break;
      end

      if (out_if.out_valid && first_valid < 0) begin
        first_valid = cyc;
        check("first_valid_lat", cyc, 3);
      end

      if (out_if.out_valid && out_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", out_if.out_data, 0);
        end else begin
          check("out_data", out_if.out_data, exp_q.pop_front());
          check("out_last", out_if.out_last, exp_q.size() == 0);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end

      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_data  = out_if.out_data;
      prev_last  = out_if.out_last;

      if (cyc > budget) begin
        check("timeout_done", 0, 1);
        break;
      end
      step();
      cyc++;
    end

    start = 1'b0;
    seen  = 1'b0;
    repeat (3) begin
      step();
      if (out_if.out_valid || done || busy) seen = 1'b1;
    end
    check("idle_after_done", seen, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_if.out_valid, 0);
    check({tag, "_last"}, out_if.out_last, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_data"}, out_if.out_data, 0);
  endtask

  initial begin
    int hs;
    logic seen;

    reset_n          = 1'b0;
    start            = 1'b0;
    base_addr        = '0;
    word_count       = '0;
    out_if.out_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    step();

    run(8'h10, 9'd4, 0, -1);
    run(8'hFE, 9'd4, 0, -1);
    run(8'h33, 9'd8, 1, -1);

    // Zero-length request: done only, no data, never busy.
    start      = 1'b1;
    base_addr  = 8'h55;
    word_count = 9'd0;
    step();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", out_if.out_valid, 0);
    seen = 1'b0;
    repeat (4) begin
      step();
      if (out_if.out_valid || done || busy) seen = 1'b1;
    end
    check("zero_quiet", seen, 0);

    run(8'h60, 9'd6, 0, 1);

    // Reset in the middle of a run after two words have been accepted.
    out_if.out_ready = 1'b1;
    start            = 1'b1;
    base_addr        = 8'h40;
    word_count       = 9'd6;
    step();
    start = 1'b0;
    hs    = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      if (out_if.out_valid && out_if.out_ready) begin
        check("pre_rst_data", out_if.out_data, rom_word(8'(8'h40 + hs)));
        hs++;
      end
      if (hs < 2) step();
    end
    check("pre_rst_words", hs, 2);
    step();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    step();
    reset_n = 1'b1;
    step();
    run(8'h20, 9'd2, 0, -1);

    for (int r = 0; r < 10; r++) begin
      run(8'($urandom), 9'($urandom_range(1, 24)), int'($urandom_range(0, 2)), -1);
    end
    run(8'hC3, 9'd256, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/r_mem_reader.md
Name: r_mem_reader

Overview:
- Sequencer directly upstream and downstream of the single-port M4K constant ROM (the R/modulus operand store) in the ModExp datapath.
- Drives the ROM address and consumes its registered q. Streams a contiguous run of operand words to the Montgomery multiplier over a valid/ready handshake.
- Absorbs the ROM's fixed read latency and downstream backpressure with a small credit-limited output FIFO.

Parameters:
- ADDR_WIDTH, 8: ROM address width.
- DATA_WIDTH, 32: ROM word width.
- READ_LATENCY, 2: cycles from mem_address change to the matching mem_q. Address register plus output register.
- FIFO_DEPTH, 4: output buffer entries. Must be >= READ_LATENCY+1 and a power of 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address, captured on an accepted start.
- word_count  in  ADDR_WIDTH+1  number of words to read, 0..2^ADDR_WIDTH, captured on an accepted start.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- mem_address  out  ADDR_WIDTH  registered ROM address.
- mem_q  in  DATA_WIDTH  ROM read data.
- out_data  out  DATA_WIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high.
- out_last  out  1  high with the final word of the run.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, mem_address=0, out_data=0; FIFO empty; all counters and tag pipe cleared.
- State machine has three states: IDLE, ISSUE, DRAIN.
- IDLE:
  - A start with word_count>0 captures base_addr and word_count, sets busy, and goes to ISSUE.
  - A start with word_count=0 pulses done on the next cycle. No output is produced and busy stays 0.
- ISSUE:
  - Each cycle, issue when (inflight + fifo_count) < FIFO_DEPTH.
  - An issue loads mem_address with the next address and pushes a valid tag into a READ_LATENCY-deep tag pipe. A tag marks the last word when it is the final issue.
  - Addresses increment modulo 2^ADDR_WIDTH; base_addr + word_count overflow wraps to 0.
  - After the final issue, go to DRAIN.
- DRAIN: when the FIFO is empty, no tags remain in flight and the last word has been accepted, pulse done, clear busy and return to IDLE.
- Data capture:
  - When a tag leaves the pipe, write mem_q into the FIFO together with its last flag.
  - mem_q is ignored whenever no tag is exiting. The ROM output is not reset, so it may hold garbage.
- Latency: the first out_valid appears READ_LATENCY+1 cycles after the accepted start edge; out_data is the FIFO head, not a direct pass-through of mem_q.
- Throughput: with out_ready held high, one word per cycle after the initial fill, with no bubbles.
- Credit rule: the FIFO never overflows under any out_ready pattern; a write to a full FIFO is a design error and carries an assertion.
- Simultaneous FIFO push and pop is allowed, including when the FIFO is full, because the pop occurs first.
- start while busy is ignored; the captured parameters stay unchanged.
- out_data and out_last are held stable while out_valid=1 and out_ready=0.
- reset_n asserted mid-run returns everything to reset values immediately. In-flight ROM data is discarded; no done pulse.
- word_count = 2^ADDR_WIDTH reads the whole ROM once, wrapping back to base_addr-1.

Test Plan:
- ROM word i = i+0x100; base=0x10, count=4, out_ready=1 -> out_data 0x110,0x111,0x112,0x113 on consecutive cycles; out_last on 0x113; first valid 3 cycles after start; done one cycle after the last accept.
- base=0xFE, count=4 -> words from addresses 0xFE,0xFF,0x00,0x01 in that order.
- count=8, out_ready toggled 1,0,0,1 repeating -> all 8 words in order with no loss or duplicate; held data stable while stalled; FIFO never exceeds 4 entries.
- count=0 -> done pulse 1 cycle later; out_valid never rises; busy stays 0.
- A second start mid-run with base=0x80 -> ignored; the run completes with the original addresses.
- reset_n dropped after 2 words accepted of count=6 -> all outputs 0 immediately; a fresh start base=0x20, count=2 after release yields 0x120,0x121 only.
